// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control matrix of the six-state ring-counter
// machine. It holds the opcode encodings, the bit positions of the 12-bit
// control word and a helper that tells defined opcodes from undefined ones.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int OP_W  = 4;
    localparam int CON_W = 12;

    typedef enum logic [OP_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_NOP = 4'h3,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit positions inside the control word
    localparam int CON_PC_INC  = 11;
    localparam int CON_PC_OE   = 10;
    localparam int CON_MAR_LD  = 9;
    localparam int CON_RAM_OE  = 8;
    localparam int CON_IR_LD   = 7;
    localparam int CON_IR_OE   = 6;
    localparam int CON_A_LD    = 5;
    localparam int CON_A_OE    = 4;
    localparam int CON_ALU_SUB = 3;
    localparam int CON_ALU_OE  = 2;
    localparam int CON_B_LD    = 1;
    localparam int CON_OUT_LD  = 0;

    // OP_NOP is only the reset value of the opcode register; fetching it
    // from the bus is still an undefined instruction.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/onehot_chk.sv
// ----------------------------------------------------------------------------
// onehot_chk
// Purely combinational integrity check of the six ring-counter states.
// Ports:
//   s_vec    in  6  timing states {S5..S0}
//   one_hot  out 1  exactly one bit of s_vec is set
//   all_zero out 1  no bit of s_vec is set (ring counter reload)
// ----------------------------------------------------------------------------
module onehot_chk (
    input  logic [5:0] s_vec,
    output logic       one_hot,
    output logic       all_zero
);

    logic [2:0] count;

    always_comb begin
        count = 3'd0;
        for (int i = 0; i < 6; i++) begin
            count = count + {2'b00, s_vec[i]};
        end
        one_hot  = (count == 3'd1);
        all_zero = (count == 3'd0);
    end

endmodule

// File: rtl/control_matrix.sv
// ----------------------------------------------------------------------------
// control_matrix
// Combines the one-hot timing state S0..S5 with the latched opcode to drive
// the datapath control word. Also owns the halt latch, sticky error flags
// and the retired-instruction counter.
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous active-high, clears all state
//   clr        in   1      synchronous restart, keeps sticky flags and count
//   s0..s5     in   1 ea   one-hot timing states
//   bus_op     in   OP_W   W-bus[7:4], opcode while S2 is active
//   con        out  12     control word (PC_INC..OUT_LD)
//   hlt        out  1      halt latch
//   ill_op     out  1      sticky undefined-opcode flag
//   state_err  out  1      sticky non-one-hot flag
//   instr_cnt  out  CNT_W  instructions retired, wraps
// ----------------------------------------------------------------------------
module control_matrix
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    input  logic             s5,
    input  logic [OP_W-1:0]  bus_op,
    output logic [CON_W-1:0] con,
    output logic             hlt,
    output logic             ill_op,
    output logic             state_err,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [5:0]       s_vec;
    logic             one_hot;
    logic             all_zero;

    logic [OP_W-1:0]  op_q,        op_d;
    logic             hlt_q,       hlt_d;
    logic             ill_op_q,    ill_op_d;
    logic             state_err_q, state_err_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             grace_q,     grace_d;

    logic [CON_W-1:0] con_dec;
    logic             con_force;

    assign s_vec = {s5, s4, s3, s2, s1, s0};

    onehot_chk u_onehot_chk (
        .s_vec    (s_vec),
        .one_hot  (one_hot),
        .all_zero (all_zero)
    );

    // Raw decode of timing state and opcode. Execute steps use op_q, which
    // was captured on the S2 edge, so S2 itself only sees fetch signals.
    always_comb begin
        con_dec = '0;
        if (s0) begin
            con_dec[CON_PC_OE]  = 1'b1;
            con_dec[CON_MAR_LD] = 1'b1;
        end
        if (s1) begin
            con_dec[CON_PC_INC] = 1'b1;
        end
        if (s2) begin
            con_dec[CON_RAM_OE] = 1'b1;
            con_dec[CON_IR_LD]  = 1'b1;
        end
        if (s3) begin
            case (op_q)
                OP_LDA, OP_ADD, OP_SUB: begin
                    con_dec[CON_IR_OE]  = 1'b1;
                    con_dec[CON_MAR_LD] = 1'b1;
                end
                OP_OUT: begin
                    con_dec[CON_A_OE]   = 1'b1;
                    con_dec[CON_OUT_LD] = 1'b1;
                end
                default: ;
            endcase
        end
        if (s4) begin
            case (op_q)
                OP_LDA: begin
                    con_dec[CON_RAM_OE] = 1'b1;
                    con_dec[CON_A_LD]   = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    con_dec[CON_RAM_OE]  = 1'b1;
                    con_dec[CON_B_LD]    = 1'b1;
                    con_dec[CON_ALU_SUB] = (op_q == OP_SUB);
                end
                default: ;
            endcase
        end
        if (s5) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    con_dec[CON_ALU_OE]  = 1'b1;
                    con_dec[CON_A_LD]    = 1'b1;
                    con_dec[CON_ALU_SUB] = (op_q == OP_SUB);
                end
                default: ;
            endcase
        end
    end

    // The control word is silenced whenever the machine is halted, being
    // restarted, or the timing vector cannot be trusted.
    assign con_force = reset | clr | hlt_q | ~one_hot;
    assign con       = con_force ? '0 : con_dec;

    // Next-state logic. clr restarts the instruction stream but leaves the
    // sticky flags and the counter alone. While halted the timing vector is
    // frozen, so neither capture, counting nor checking happens.
    always_comb begin
        op_d        = op_q;
        hlt_d       = hlt_q;
        ill_op_d    = ill_op_q;
        state_err_d = state_err_q;
        instr_cnt_d = instr_cnt_q;
        grace_d     = 1'b0;
        if (clr) begin
            op_d    = OP_NOP;
            hlt_d   = 1'b0;
            grace_d = 1'b1;
        end else if (!hlt_q) begin
            if (s2) begin
                op_d = bus_op;
                if (!is_legal_op(bus_op)) begin
                    ill_op_d = 1'b1;
                end
            end
            if (s3 && (op_q == OP_HLT)) begin
                hlt_d = 1'b1;
            end
            if (s5) begin
                instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // An empty vector right after restart is the ring counter
            // reloading and must not be flagged.
            if (!one_hot && !(grace_q && all_zero)) begin
                state_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_NOP;
            hlt_q       <= 1'b0;
            ill_op_q    <= 1'b0;
            state_err_q <= 1'b0;
            instr_cnt_q <= '0;
            grace_q     <= 1'b1;
        end else begin
            op_q        <= op_d;
            hlt_q       <= hlt_d;
            ill_op_q    <= ill_op_d;
            state_err_q <= state_err_d;
            instr_cnt_q <= instr_cnt_d;
            grace_q     <= grace_d;
        end
    end

    assign hlt       = hlt_q;
    assign ill_op    = ill_op_q;
    assign state_err = state_err_q;
    assign instr_cnt = instr_cnt_q;

endmodule
